uart_tx: RTL and testbench

//  UART transmitter serializing bytes popped from the TX FIFO onto txd.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_baud_counter.sv | 21 ++
 rtl/uart_tx.sv | 89 ++++++++
 tb/tb_uart_tx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line levels.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} uart_tx_state_t;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..div and pulses tick on the last count of each bit period.
module uart_baud_counter #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    always_comb begin
        tick_o = en_i && (cnt_q == div_i);
        cnt_d  = (clear_i || tick_o) ? '0 : en_i ? cnt_q + DIV_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: pops bytes from the TX fifo and serializes start, LSB-first data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tx_en_i,
    input  logic                 nstop_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_SIZE-1:0] fifo_rd_data_i,
    output logic                 fifo_rd_en_o,
    output logic                 txd_o,
    output logic                 busy_o
);
    localparam int BW = $clog2(DATA_SIZE);
    localparam logic [BW-1:0] LAST = BW'(DATA_SIZE - 1);
    uart_tx_state_t       state_q, state_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 nstop_q, nstop_d, txd_q, txd_d, clear, tick;
    uart_baud_counter #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear),
        .en_i   (busy_o && state_q != LOAD),
        .div_i  (div_q),
        .tick_o (tick)
    );
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        div_d        = div_q;
        nstop_d      = nstop_q;
        clear        = 1'b0;
        fifo_rd_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                // gated by reset so the fifo is never popped while held in reset
                fifo_rd_en_o = rst_ni && tx_en_i && !fifo_empty_i;
                state_d      = fifo_rd_en_o ? LOAD : IDLE;
            end
            LOAD: begin
                shift_d = fifo_rd_data_i;
                div_d   = div_i;
                nstop_d = nstop_i;
                bit_d   = '0;
                clear   = 1'b1;
                state_d = START;
            end
            START: state_d = tick ? DATA : START;
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                bit_d   = (bit_q == LAST) ? '0 : bit_q + BW'(1);
                state_d = (bit_q == LAST) ? STOP : DATA;
            end
            STOP: if (tick) begin
                bit_d   = (bit_q == BW'(nstop_q)) ? '0 : bit_q + BW'(1);
                state_d = (bit_q == BW'(nstop_q)) ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
        txd_d = (state_d == START) ? UART_START_LEVEL : (state_d == DATA) ? shift_d[0] : UART_IDLE_LEVEL;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            nstop_q <= 1'b0;
            txd_q   <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            nstop_q <= nstop_d;
            txd_q   <= txd_d;
        end
    end
    assign txd_o  = txd_q;
    assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks of uart_tx against a small pointer-based fifo model.
module tb_uart_tx;
    logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, nstop = 1'b0;
    logic [15:0] div = '0;
    logic [7:0] rd_data = '0;
    logic rd_en, txd, busy, fifo_empty, rd_en_prev = 1'b0;
    logic [7:0] mem [0:15];
    int wp = 0, rp = 0, checks = 0, errors = 0, pops = 0, bad = 0;

    uart_tx #(.DATA_SIZE(8), .DIV_WIDTH(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tx_en_i       (tx_en),
        .nstop_i       (nstop),
        .div_i         (div),
        .fifo_empty_i  (fifo_empty),
        .fifo_rd_data_i(rd_data),
        .fifo_rd_en_o  (rd_en),
        .txd_o         (txd),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    assign fifo_empty = (wp == rp);
    always @(posedge clk) if (rd_en) begin
        rd_data <= mem[rp % 16];
        rp <= rp + 1;
    end
    always @(negedge clk) begin
        if (rd_en) pops++;
        if (rd_en && (busy || rd_en_prev)) bad++;
        rd_en_prev = rd_en;
    end

    task automatic push(input logic [7:0] b);
        mem[wp % 16] = b;
        wp++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // waits for the start bit, then checks every cycle of the frame against the expected bit
    task automatic frame(input string tag, input logic [7:0] b, input int d, input int ns,
                         input int gap, input int act_at, input int act);
        int t = 0;
        bit ok = 1'b1, bsy = 1'b1;
        logic e;
        while (txd !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " start"}, 32'(t < 5000), 1);
        if (gap >= 0) chk({tag, " gap"}, t, gap);
        for (int i = 0; i < 10 + ns; i++)
            for (int c = 0; c <= d; c++) begin
                e = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
                if (txd !== e) ok = 1'b0;
                if (busy !== 1'b1) bsy = 1'b0;
                if (i * (d + 1) + c == act_at) begin
                    if (act == 1) tx_en = 1'b0;
                    else if (act == 2) div = 16'd9;
                end
                @(negedge clk);
            end
        chk({tag, " bits"}, 32'(ok), 1);
        chk({tag, " busy"}, 32'(bsy), 1);
        chk({tag, " end"}, {busy, txd}, 2'b01);
    endtask

    initial begin
        bit ok;
        int w;
        repeat (3) @(negedge clk);
        chk("reset state", {txd, busy, rd_en}, 3'b100);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk("reset mid idle", {txd, busy, rd_en}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;

        div = 16'd3; nstop = 1'b0;
        push(8'hA5);
        tx_en = 1'b1;
        frame("t2 A5", 8'hA5, 3, 0, -1, -1, 0);
        chk("t2 pops", pops, 1);

        ok = 1'b1;
        repeat (100) begin
            if ({txd, busy, rd_en} !== 3'b100) ok = 1'b0;
            @(negedge clk);
        end
        chk("t3 empty idle", 32'(ok), 1);

        div = 16'd0; nstop = 1'b1;
        push(8'h00); push(8'hFF);
        frame("t4 00", 8'h00, 0, 1, -1, -1, 0);
        frame("t4 FF", 8'hFF, 0, 1, 2, -1, 0);
        chk("t4 pops", pops, 3);

        div = 16'd7; nstop = 1'b0;
        push(8'h3C); push(8'hC3);
        frame("t5 3C", 8'h3C, 7, 0, -1, 35, 1);
        ok = 1'b1;
        repeat (100) begin
            if ({txd, busy, rd_en} !== 3'b100) ok = 1'b0;
            @(negedge clk);
        end
        chk("t5 no pop", 32'(ok), 1);
        chk("t5 pops held", pops, 4);
        tx_en = 1'b1;
        frame("t5 C3", 8'hC3, 7, 0, 2, -1, 0);
        chk("t5 pops", pops, 5);

        div = 16'd3;
        push(8'h5A); push(8'h96);
        frame("t6 5A", 8'h5A, 3, 0, -1, 20, 2);
        frame("t6 96", 8'h96, 9, 0, 2, -1, 0);
        chk("t6 pops", pops, 7);

        div = 16'd3;
        push(8'h81);
        w = 0;
        while (txd !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("t7 start", 32'(w < 100), 1);
        repeat (15) @(negedge clk);
        push(8'hE7);
        #2 rst_n = 1'b0;
        #1 chk("t7 reset", {txd, busy, rd_en}, 3'b100);
        chk("t7 pops", pops, 8);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        frame("t7 E7", 8'hE7, 3, 0, -1, -1, 0);
        chk("t7 pops after", pops, 9);
        chk("pop protocol", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
